// File: rtl/dec_key_sched_pkg.sv
// -----------------------------------------------------------------------------
// dec_key_sched_pkg
// Shared definitions for the AES-128 decrypt key-schedule engine:
//   NR / KW          round count and key width (AES-128 only)
//   state_e          control FSM states
//   byte_t/word_t    byte and 32-bit word views used by the expansion round
//   rcon_f           round constant for expansion round 1..10
//   rot_word_f       cyclic byte rotation of a key word (RotWord)
// Optional build macro used by the engine: DEC_KEY_ZEROIZE_EN.
// -----------------------------------------------------------------------------
package dec_key_sched_pkg;

    localparam int NR = 10;
    localparam int KW = 128;

    typedef logic [7:0]    byte_t;
    typedef logic [31:0]   word_t;
    typedef logic [KW-1:0] key_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2,
        ST_STREAM = 2'd3
    } state_e;

    // Rcon for expansion round 1..10; any other index yields zero.
    function automatic byte_t rcon_f(input logic [3:0] round);
        byte_t r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Byte 0 sits in the most significant byte, so RotWord is a left rotate by 8.
    function automatic word_t rot_word_f(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/dec_key_sched_sbox.sv
// -----------------------------------------------------------------------------
// dec_key_sched_sbox
// Forward AES S-box, purely combinational. Computed as the GF(2^8) inverse
// (x^254, which maps 0 to 0) followed by the AES affine transform.
// Ports:
//   in_i   [7:0]  input byte
//   out_o  [7:0]  S-box output byte
// -----------------------------------------------------------------------------
module dec_key_sched_sbox
    import dec_key_sched_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    byte_t inv_s;

    function automatic byte_t xtime_f(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul_f(input byte_t a, input byte_t b);
        byte_t acc;
        byte_t x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end else begin
                acc = acc;
            end
            x = xtime_f(x);
        end
        return acc;
    endfunction

    // x^254 via the chain x^3, x^7, ..., x^127, then one final squaring.
    function automatic byte_t gf_inv_f(input byte_t a);
        byte_t p;
        p = a;
        for (int i = 0; i < 6; i++) begin
            p = gf_mul_f(gf_mul_f(p, p), a);
        end
        return gf_mul_f(p, p);
    endfunction

    // Inverse followed by affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    always_comb begin
        inv_s = gf_inv_f(in_i);
        out_o = inv_s
              ^ {inv_s[6:0], inv_s[7]}
              ^ {inv_s[5:0], inv_s[7:6]}
              ^ {inv_s[4:0], inv_s[7:5]}
              ^ {inv_s[3:0], inv_s[7:4]}
              ^ 8'h63;
    end

endmodule

// File: rtl/dec_key_sched.sv
// -----------------------------------------------------------------------------
// dec_key_sched
// Iterative AES-128 key-schedule engine for the decryptor. A cipher key is
// expanded once, one round per cycle, into an 11-entry round-key store. On
// start the round keys are streamed in reverse order (10 down to 0) with
// their round index over a valid/ready handshake.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   key_in[127:0], key_valid  cipher key (byte 0 in [127:120]) and its valid
//   key_ready                 a key is accepted this cycle if key_valid
//   keys_ok                   store holds a complete expanded schedule
//   start, start_ready        reverse-stream request and its acceptance
//   rk_data[127:0], rk_round  current round key and its round index
//   rk_valid, rk_ready        stream handshake
//   rk_last                   rk_data is round 0
// Build option: DEC_KEY_ZEROIZE_EN clears the store on reset and on every
// key load, and forces rk_data to zero whenever rk_valid is low.
// -----------------------------------------------------------------------------
module dec_key_sched
    import dec_key_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [KW-1:0] key_in,
    input  logic          key_valid,
    output logic          key_ready,
    output logic          keys_ok,
    input  logic          start,
    output logic          start_ready,
    output logic [KW-1:0] rk_data,
    output logic [3:0]    rk_round,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic          rk_last
);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          keys_ok_q, keys_ok_d;
    logic          key_ready_q, key_ready_d;
    logic          start_ready_q, start_ready_d;
    logic          rk_valid_q, rk_valid_d;
    logic          rk_last_q, rk_last_d;
    key_t          rk_data_q, rk_data_d;
    logic [3:0]    rk_round_q, rk_round_d;

    key_t          store_q [0:NR];

    logic          load_s;
    logic          exp_we_s;
    logic [3:0]    prev_idx_s;
    key_t          prev_key_s;
    word_t         rot_s;
    word_t         sub_word_s;
    word_t         w0_s, w1_s, w2_s, w3_s;
    key_t          next_key_s;
    logic [3:0]    rd_idx_s;
    key_t          rd_key_s;

    // Previous round key feeding the expansion round selected by cnt_q.
    always_comb begin
        prev_idx_s = cnt_q - 4'd1;
        if (prev_idx_s <= 4'(NR)) begin
            prev_key_s = store_q[prev_idx_s];
        end else begin
            prev_key_s = '0;
        end
    end

    assign rot_s = rot_word_f(prev_key_s[31:0]);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        dec_key_sched_sbox u_sbox (
            .in_i  (rot_s[8*g +: 8]),
            .out_o (sub_word_s[8*g +: 8])
        );
    end

    // One AES-128 expansion round: word 0 mixes SubWord/Rcon, the rest chain.
    always_comb begin
        w0_s       = prev_key_s[127:96] ^ sub_word_s ^ {rcon_f(cnt_q), 24'h000000};
        w1_s       = prev_key_s[95:64]  ^ w0_s;
        w2_s       = prev_key_s[63:32]  ^ w1_s;
        w3_s       = prev_key_s[31:0]   ^ w2_s;
        next_key_s = {w0_s, w1_s, w2_s, w3_s};
    end

    // Stream read port: next lower round while streaming, round NR otherwise
    // so the first beat is ready when start is accepted.
    always_comb begin
        if (state_q == ST_STREAM) begin
            rd_idx_s = rk_round_q - 4'd1;
        end else begin
            rd_idx_s = 4'(NR);
        end
        if (rd_idx_s <= 4'(NR)) begin
            rd_key_s = store_q[rd_idx_s];
        end else begin
            rd_key_s = '0;
        end
    end

    // Control FSM next-state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        keys_ok_d  = keys_ok_q;
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_round_d = rk_round_q;
        rk_last_d  = rk_last_q;
        load_s     = 1'b0;
        exp_we_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_READY: begin
                // A key load has priority over a simultaneous start.
                if (key_valid) begin
                    load_s    = 1'b1;
                    state_d   = ST_EXPAND;
                    cnt_d     = 4'd1;
                    keys_ok_d = 1'b0;
                end else if ((state_q == ST_READY) && start) begin
                    state_d    = ST_STREAM;
                    rk_valid_d = 1'b1;
                    rk_round_d = 4'(NR);
                    rk_data_d  = rd_key_s;
                    rk_last_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_EXPAND: begin
                exp_we_s = 1'b1;
                if (cnt_q == 4'(NR)) begin
                    state_d   = ST_READY;
                    keys_ok_d = 1'b1;
                    cnt_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_STREAM: begin
                if (rk_ready && rk_last_q) begin
                    state_d    = ST_READY;
                    rk_valid_d = 1'b0;
                    rk_last_d  = 1'b0;
`ifdef DEC_KEY_ZEROIZE_EN
                    rk_data_d  = '0;
`else
                    rk_data_d  = rk_data_q;
`endif
                end else if (rk_ready) begin
                    rk_round_d = rk_round_q - 4'd1;
                    rk_data_d  = rd_key_s;
                    rk_last_d  = (rk_round_q == 4'd1);
                end else begin
                    rk_round_d = rk_round_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        key_ready_d   = (state_d == ST_IDLE) || (state_d == ST_READY);
        start_ready_d = (state_d == ST_READY);
    end

    // Control state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            keys_ok_q     <= 1'b0;
            key_ready_q   <= 1'b1;
            start_ready_q <= 1'b0;
            rk_valid_q    <= 1'b0;
            rk_last_q     <= 1'b0;
            rk_data_q     <= '0;
            rk_round_q    <= 4'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            keys_ok_q     <= keys_ok_d;
            key_ready_q   <= key_ready_d;
            start_ready_q <= start_ready_d;
            rk_valid_q    <= rk_valid_d;
            rk_last_q     <= rk_last_d;
            rk_data_q     <= rk_data_d;
            rk_round_q    <= rk_round_d;
        end
    end

    // Round-key store: key load writes entry 0, expansion writes entry cnt_q.
    always_ff @(posedge clk) begin
`ifdef DEC_KEY_ZEROIZE_EN
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                store_q[i] <= '0;
            end
        end else if (load_s) begin
            for (int i = 1; i <= NR; i++) begin
                store_q[i] <= '0;
            end
            store_q[0] <= key_in;
        end else if (exp_we_s && (cnt_q <= 4'(NR))) begin
            store_q[cnt_q] <= next_key_s;
        end else begin
            store_q[0] <= store_q[0];
        end
`else
        if (!rst && load_s) begin
            store_q[0] <= key_in;
        end else if (!rst && exp_we_s && (cnt_q <= 4'(NR))) begin
            store_q[cnt_q] <= next_key_s;
        end else begin
            store_q[0] <= store_q[0];
        end
`endif
    end

    assign key_ready   = key_ready_q;
    assign keys_ok     = keys_ok_q;
    assign start_ready = start_ready_q;
    assign rk_valid    = rk_valid_q;
    assign rk_data     = rk_data_q;
    assign rk_round    = rk_round_q;
    assign rk_last     = rk_last_q;

endmodule
